// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter.
// Pins are driven only through active-high pull-low enables.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int RTS_CYCLES     = 50,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2clk_in,
   input  logic       ps2data_in,
   input  logic [7:0] data,
   input  logic       send,
   output logic       ps2clk_oe,
   output logic       ps2data_oe,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int DMAX = (INHIBIT_CYCLES > RTS_CYCLES) ?
                         INHIBIT_CYCLES : RTS_CYCLES;
   localparam int DW   = $clog2(DMAX + 1);
   localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_TXBITS,
      S_ACK,
      S_WAITIDLE
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      clk_sync, dat_sync;
   logic            clk_prev;
   logic            clk_s, dat_s, fe;
   logic [DW-1:0]   dcnt_q;
   logic [TW-1:0]   tcnt_q;
   logic [9:0]      frame_q;
   logic [3:0]      bcnt_q;
   logic            dbit_q;
   logic            nack_q;
   logic            done_q, error_q;
   logic            accept, timeout, fin_ok, fin_err;
   logic            tx_live;

   assign clk_s   = clk_sync[1];
   assign dat_s   = dat_sync[1];
   assign fe      = clk_prev & ~clk_s;

   // a send arriving with the completion pulse is dropped
   assign accept  = send & ~done_q & ~error_q;

   assign tx_live = (state_q == S_TXBITS) ||
                    (state_q == S_ACK) ||
                    (state_q == S_WAITIDLE);
   assign timeout = tx_live &&
                    (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

   assign done    = done_q;
   assign error   = error_q;

   // two-stage pin synchronizers plus previous clock sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[0], ps2clk_in};
         dat_sync <= {dat_sync[0], ps2data_in};
         clk_prev <= clk_sync[1];
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next-state logic and completion decode
   always_comb begin
      state_d = state_q;
      fin_ok  = 1'b0;
      fin_err = 1'b0;
      unique case (state_q)
         S_IDLE:
            if (send && accept) state_d = S_INHIBIT;
         S_INHIBIT:
            if (dcnt_q == DW'(INHIBIT_CYCLES - 1))
               state_d = S_RTS;
         S_RTS:
            if (dcnt_q == DW'(RTS_CYCLES - 1))
               state_d = S_TXBITS;
         S_TXBITS:
            if (fe && bcnt_q == 4'd9) state_d = S_ACK;
         S_ACK:
            if (fe) state_d = S_WAITIDLE;
         S_WAITIDLE:
            if (clk_s && dat_s) begin
               state_d = S_IDLE;
               fin_ok  = ~nack_q;
               fin_err = nack_q;
            end
         default: state_d = S_IDLE;
      endcase
      if (timeout) begin
         state_d = S_IDLE;
         fin_ok  = 1'b0;
         fin_err = 1'b1;
      end
   end

   // pin enables: state-decoded so reset releases them at once
   always_comb begin
      busy       = (state_q != S_IDLE);
      ps2clk_oe  = (state_q == S_INHIBIT) ||
                   (state_q == S_RTS);
      ps2data_oe = (state_q == S_RTS) ||
                   ((state_q == S_TXBITS) && dbit_q);
   end

   // inhibit / request-to-send hold counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         dcnt_q <= '0;
      else if (state_d != state_q)
         dcnt_q <= '0;
      else if (state_q == S_INHIBIT || state_q == S_RTS)
         dcnt_q <= dcnt_q + DW'(1);
   end

   // device clock watchdog, restarted by every falling edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tcnt_q <= '0;
      else if ((state_q != S_TXBITS && state_d == S_TXBITS) || fe)
         tcnt_q <= '0;
      else if (tx_live)
         tcnt_q <= tcnt_q + TW'(1);
   end

   // frame latch, bit shifting and acknowledge capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q <= '1;
         bcnt_q  <= '0;
         dbit_q  <= 1'b0;
         nack_q  <= 1'b0;
      end else if (state_q == S_IDLE) begin
         if (send && accept) begin
            frame_q <= {1'b1, ~^data, data};
            bcnt_q  <= '0;
            nack_q  <= 1'b0;
         end
      end else if (state_q == S_RTS) begin
         dbit_q <= 1'b1;
      end else if (state_q == S_TXBITS && fe) begin
         dbit_q  <= ~frame_q[0];
         frame_q <= {1'b1, frame_q[9:1]};
         bcnt_q  <= bcnt_q + 4'd1;
      end else if (state_q == S_ACK && fe) begin
         nack_q <= dat_s;
      end
   end

   // completion pulses, coincident with busy falling
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         done_q  <= fin_ok;
         error_q <= fin_err;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench for ps2_host_tx
// with a behavioural PS/2 device on the bus.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int INH  = 20;
   localparam int RTS  = 4;
   localparam int TOUT = 200;
   localparam int HALF = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] cmd = 8'h00;
   logic       send = 1'b0;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   wire logic  pclk, pdat;
   logic       ps2clk_oe, ps2data_oe;
   logic       busy, done, error;

   int vecs = 0;
   int miss = 0;
   int cyc = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;

   assign pclk = ~(ps2clk_oe | dev_clk_low);
   assign pdat = ~(ps2data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .RTS_CYCLES(RTS),
      .TIMEOUT_CYCLES(TOUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ps2clk_in(pclk),
      .ps2data_in(pdat),
      .data(cmd),
      .send(send),
      .ps2clk_oe(ps2clk_oe),
      .ps2data_oe(ps2data_oe),
      .busy(busy),
      .done(done),
      .error(error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done)  done_cnt <= done_cnt + 1;
      if (error) err_cnt  <= err_cnt + 1;
      if (done && error) both_cnt <= both_cnt + 1;
   end

   // expected line frame: stop, odd parity, d7..d0, start
   function automatic logic [10:0] exp_frame(input logic [7:0] b);
      logic par;
      par = (($countones(b) % 2) == 0);
      return {1'b1, par, b, 1'b0};
   endfunction

   task automatic do_send(input logic [7:0] b);
      @(negedge clk);
      cmd  = b;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      cmd  = 8'($urandom);
   endtask

   // device side: waits for request-to-send, clocks 11 bits
   task automatic dev_xfer(input bit ack, input int inj_at,
                           input int rst_at,
                           output logic [10:0] bits,
                           output bit got,
                           output logic oe_before);
      bits = '0;
      got = 1'b0;
      oe_before = 1'b0;
      for (int k = 0; k < INH + RTS + 100; k++) begin
         @(negedge clk);
         if (busy && !ps2clk_oe && ps2data_oe) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) return;
      bits[0] = pdat;
      repeat (4) @(negedge clk);
      for (int i = 1; i <= 10; i++) begin
         dev_clk_low = 1'b1;
         for (int j = 0; j < HALF; j++) begin
            @(negedge clk);
            if (i == inj_at && j == 2) begin
               cmd  = 8'h55;
               send = 1'b1;
            end
            if (i == inj_at && j == 3) send = 1'b0;
            if (i == rst_at && j == 6) begin
               oe_before = ps2data_oe;
               rst_n = 1'b0;
               return;
            end
         end
         bits[i] = pdat;
         dev_clk_low = 1'b0;
         repeat (HALF) @(negedge clk);
      end
      dev_data_low = ack;
      repeat (2) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_data_low = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      vecs++;
      if (!ok) begin
         miss++;
         $display("FAIL idle_wait: busy=%b want 0", busy);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vecs++;
      if ({ps2clk_oe, ps2data_oe, busy, done, error} !== 5'b0) begin
         miss++;
         $display("FAIL reset_outs: got %b want 00000",
                  {ps2clk_oe, ps2data_oe, busy, done, error});
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      vecs++;
      if ({ps2clk_oe, ps2data_oe, busy} !== 3'b0) begin
         miss++;
         $display("FAIL post_reset_idle: got %b want 000",
                  {ps2clk_oe, ps2data_oe, busy});
      end
   endtask

   task automatic test_known();
      logic [7:0]  set [3] = '{8'hED, 8'hFF, 8'h01};
      logic [10:0] rx;
      bit          got;
      logic        ob;
      int          d0, e0;
      for (int i = 0; i < 3; i++) begin
         d0 = done_cnt;
         e0 = err_cnt;
         do_send(set[i]);
         dev_xfer(1'b1, 0, 0, rx, got, ob);
         wait_idle();
         vecs++;
         if (rx !== exp_frame(set[i])) begin
            miss++;
            $display("FAIL known_frame %h: got %b want %b",
                     set[i], rx, exp_frame(set[i]));
         end
         vecs++;
         if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            miss++;
            $display("FAIL known_pulses %h: done %0d err %0d want 1 0",
                     set[i], done_cnt - d0, err_cnt - e0);
         end
         vecs++;
         if (busy !== 1'b0) begin
            miss++;
            $display("FAIL known_busy: got %b want 0", busy);
         end
      end
   endtask

   task automatic test_timing();
      logic [7:0]  b;
      logic [10:0] rx;
      bit          got;
      logic        ob;
      b = 8'($urandom);
      do_send(b);
      vecs++;
      if ({busy, ps2clk_oe, ps2data_oe} !== 3'b110) begin
         miss++;
         $display("FAIL accept_n1: got %b want 110",
                  {busy, ps2clk_oe, ps2data_oe});
      end
      for (int j = 1; j <= RTS + INH; j++) begin
         @(negedge clk);
         if (j == INH - 1) begin
            vecs++;
            if (ps2data_oe !== 1'b0) begin
               miss++;
               $display("FAIL data_oe_early: got %b want 0", ps2data_oe);
            end
         end
         if (j == INH) begin
            vecs++;
            if (ps2data_oe !== 1'b1 || ps2clk_oe !== 1'b1) begin
               miss++;
               $display("FAIL rts_start: got %b%b want 11",
                        ps2clk_oe, ps2data_oe);
            end
         end
         if (j == INH + RTS - 1) begin
            vecs++;
            if (ps2clk_oe !== 1'b1) begin
               miss++;
               $display("FAIL clk_release_early: got %b want 1",
                        ps2clk_oe);
            end
         end
         if (j == INH + RTS) begin
            vecs++;
            if (ps2clk_oe !== 1'b0 || ps2data_oe !== 1'b1) begin
               miss++;
               $display("FAIL clk_release: got %b%b want 01",
                        ps2clk_oe, ps2data_oe);
            end
         end
      end
      dev_xfer(1'b1, 0, 0, rx, got, ob);
      wait_idle();
      vecs++;
      if (rx !== exp_frame(b)) begin
         miss++;
         $display("FAIL timing_frame %h: got %b want %b",
                  b, rx, exp_frame(b));
      end
   endtask

   task automatic test_random();
      logic [7:0]  b;
      logic [10:0] rx;
      bit          got, ack;
      logic        ob;
      int          d0, e0;
      for (int i = 0; i < 6; i++) begin
         b   = 8'($urandom);
         ack = ($urandom_range(0, 3) != 0);
         d0  = done_cnt;
         e0  = err_cnt;
         do_send(b);
         dev_xfer(ack, 0, 0, rx, got, ob);
         wait_idle();
         vecs++;
         if (rx !== exp_frame(b)) begin
            miss++;
            $display("FAIL rand_frame %h: got %b want %b",
                     b, rx, exp_frame(b));
         end
         vecs++;
         if (done_cnt - d0 !== int'(ack) ||
             err_cnt - e0 !== int'(!ack)) begin
            miss++;
            $display("FAIL rand_pulses %h ack=%b: done %0d err %0d",
                     b, ack, done_cnt - d0, err_cnt - e0);
         end
      end
   endtask

   task automatic test_nack();
      logic [10:0] rx;
      bit          got;
      logic        ob;
      int          d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      do_send(8'hED);
      dev_xfer(1'b0, 0, 0, rx, got, ob);
      wait_idle();
      vecs++;
      if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
         miss++;
         $display("FAIL nack_pulses: done %0d err %0d want 0 1",
                  done_cnt - d0, err_cnt - e0);
      end
      vecs++;
      if ({ps2clk_oe, ps2data_oe, busy} !== 3'b0) begin
         miss++;
         $display("FAIL nack_lines: got %b want 000",
                  {ps2clk_oe, ps2data_oe, busy});
      end
   endtask

   task automatic test_timeout();
      int t0, d0;
      bit seen;
      d0 = done_cnt;
      t0 = -1;
      seen = 1'b0;
      do_send(8'($urandom));
      for (int k = 0; k < INH + RTS + 50; k++) begin
         @(negedge clk);
         if (busy && !ps2clk_oe) begin
            t0 = cyc;
            break;
         end
      end
      for (int k = 0; k < TOUT + 100 && t0 >= 0; k++) begin
         @(negedge clk);
         if (error) begin
            seen = 1'b1;
            break;
         end
      end
      vecs++;
      if (!seen || cyc - t0 !== TOUT) begin
         miss++;
         $display("FAIL timeout_delay: seen %b got %0d want %0d",
                  seen, cyc - t0, TOUT);
      end
      vecs++;
      if ({busy, ps2clk_oe, ps2data_oe, done} !== 4'b0) begin
         miss++;
         $display("FAIL timeout_lines: got %b want 0000",
                  {busy, ps2clk_oe, ps2data_oe, done});
      end
      repeat (3) @(negedge clk);
      vecs++;
      if (done_cnt - d0 !== 0) begin
         miss++;
         $display("FAIL timeout_done: got %0d want 0", done_cnt - d0);
      end
   endtask

   task automatic test_busy_ignore();
      logic [10:0] rx;
      bit          got;
      logic        ob;
      int          d0;
      d0 = done_cnt;
      do_send(8'hF3);
      dev_xfer(1'b1, 3, 0, rx, got, ob);
      wait_idle();
      vecs++;
      if (rx !== exp_frame(8'hF3) || done_cnt - d0 !== 1) begin
         miss++;
         $display("FAIL ignore_f3: got %b done %0d want %b 1",
                  rx, done_cnt - d0, exp_frame(8'hF3));
      end
      vecs++;
      if (busy !== 1'b0) begin
         miss++;
         $display("FAIL ignore_resend: busy %b want 0", busy);
      end
      do_send(8'h55);
      dev_xfer(1'b1, 0, 0, rx, got, ob);
      wait_idle();
      vecs++;
      if (rx !== exp_frame(8'h55)) begin
         miss++;
         $display("FAIL later_55: got %b want %b",
                  rx, exp_frame(8'h55));
      end
   endtask

   task automatic test_reset_mid();
      logic [10:0] rx;
      bit          got;
      logic        ob;
      int          d0;
      logic [7:0]  b;
      b = 8'hED;
      do_send(b);
      dev_xfer(1'b1, 0, 5, rx, got, ob);
      #1;
      vecs++;
      if ({ps2clk_oe, ps2data_oe, busy} !== 3'b0) begin
         miss++;
         $display("FAIL midreset_lines: got %b want 000",
                  {ps2clk_oe, ps2data_oe, busy});
      end
      vecs++;
      if (ob !== ~b[4]) begin
         miss++;
         $display("FAIL midreset_pre_oe: got %b want %b", ob, ~b[4]);
      end
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      d0 = done_cnt;
      do_send(b);
      dev_xfer(1'b1, 0, 0, rx, got, ob);
      wait_idle();
      vecs++;
      if (rx !== exp_frame(b) || done_cnt - d0 !== 1) begin
         miss++;
         $display("FAIL post_reset_send: got %b done %0d want %b 1",
                  rx, done_cnt - d0, exp_frame(b));
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  b1, b2;
      logic [10:0] rx;
      bit          got, seen;
      logic        ob;
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      seen = 1'b0;
      do_send(b1);
      dev_xfer(1'b1, 0, 0, rx, got, ob);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      vecs++;
      if (!seen || busy !== 1'b0) begin
         miss++;
         $display("FAIL b2b_done: seen %b busy %b want 1 0", seen, busy);
      end
      cmd  = b2;
      send = 1'b1;
      @(negedge clk);
      vecs++;
      if (busy !== 1'b0) begin
         miss++;
         $display("FAIL b2b_ignored: busy %b want 0", busy);
      end
      @(negedge clk);
      send = 1'b0;
      cmd  = 8'($urandom);
      vecs++;
      if (busy !== 1'b1) begin
         miss++;
         $display("FAIL b2b_accepted: busy %b want 1", busy);
      end
      dev_xfer(1'b1, 0, 0, rx, got, ob);
      wait_idle();
      vecs++;
      if (rx !== exp_frame(b2)) begin
         miss++;
         $display("FAIL b2b_frame %h: got %b want %b",
                  b2, rx, exp_frame(b2));
      end
   endtask

   initial begin
      test_reset();
      test_known();
      test_timing();
      test_random();
      test_nack();
      test_timeout();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      vecs++;
      if (both_cnt !== 0) begin
         miss++;
         $display("FAIL done_and_error: got %0d want 0", both_cnt);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
